// File: rtl/aes50_txd_gearbox_if.sv
// ============================================================================
// Module      : aes50_txd_gearbox_if
// Description : Framer-to-gearbox word handshake (data, valid, ready).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes50_txd_gearbox_if #(
  parameter int LANES = 3,
  parameter int RATIO = 4
);
  logic [LANES*2*RATIO-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;

  // Framer side drives words and samples back-pressure
  modport master (output in_data, output in_valid, input in_ready);
  // Gearbox side consumes words and drives back-pressure
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

`default_nettype wire

// File: rtl/aes50_txd_gearbox.sv
// ============================================================================
// Module      : aes50_txd_gearbox
// Description : AES50 transmit gearbox. Buffers wide framer words in a small
//               FIFO and serialises them, one DDR slot per refclk cycle, into
//               rise/fall bit pairs per lane plus a forwarded-clock pair.
//               Optional macro AES50_TXD_PRBS_EN replaces the idle fill with
//               a PRBS7 pattern when prbs_mode is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes50_txd_gearbox #(
  parameter int         LANES       = 3,
  parameter int         RATIO       = 4,
  parameter int         DEPTH       = 4,
  parameter int         START_LEVEL = 2,
  parameter logic [1:0] IDLE_PAIR   = 2'b00
) (
  input  wire logic               refclk,
  input  wire logic               reset_n,
  input  wire logic               enable,
`ifdef AES50_TXD_PRBS_EN
  input  wire logic               prbs_mode,
`endif
  aes50_txd_gearbox_if.slave      in_if,
  output logic [2*LANES-1:0]      ddr_data,
  output logic [1:0]              clk_ddr_data,
  output logic                    active,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int SLOT_W  = 2 * LANES;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SLOTC_W = $clog2(RATIO);

  localparam logic [SLOTC_W-1:0] LAST_SLOT = SLOTC_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]   START_CNT = CNT_W'(START_LEVEL);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);

  typedef logic [RATIO-1:0][SLOT_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  word_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // Serialiser state
  state_t            state_q;
  logic [SLOTC_W-1:0] slot_q;
  word_t             word_q;
  logic [SLOT_W-1:0] ddr_q;
  logic [1:0]        clk_q;
  logic              underflow_q;

  logic              w_ready;
  logic              w_wr;
  logic              w_load;
  logic [SLOT_W-1:0] w_fill;

  assign w_ready        = (count_q < FULL_CNT);
  assign w_wr           = in_if.in_valid && w_ready;
  assign in_if.in_ready = w_ready;

  // A word leaves the FIFO only when the shifter loads: on the IDLE start
  // condition, or back-to-back at the last slot of a running word.
  always_comb begin
    w_load = 1'b0;
    case (state_q)
      ST_IDLE: w_load = enable && (count_q >= START_CNT);
      ST_RUN:  w_load = (slot_q == LAST_SLOT) && enable && (count_q != '0);
      default: w_load = 1'b0;
    endcase
  end

  // Occupancy: simultaneous write and read leave the count unchanged
  always_comb begin
    count_d = count_q;
    if (w_wr && !w_load) begin
      count_d = count_q + 1'b1;
    end else if (!w_wr && w_load) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO pointers and count; pointers wrap naturally since DEPTH is 2^n
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_wr) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (w_load) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; stale entries are harmless because reset clears the count
  always_ff @(posedge refclk) begin
    if (w_wr) begin
      mem_q[wptr_q] <= in_if.in_data;
    end
  end

`ifdef AES50_TXD_PRBS_EN
  logic [6:0] prbs_q;
  logic       w_prbs_rise;
  logic       w_prbs_fall;
  logic [6:0] w_prbs_s1;
  logic [6:0] w_prbs_s2;

  // Two PRBS7 (x^7+x^6+1) steps per cycle; the first new bit is the rise bit
  always_comb begin
    w_prbs_rise = prbs_q[6] ^ prbs_q[5];
    w_prbs_s1   = {prbs_q[5:0], w_prbs_rise};
    w_prbs_fall = w_prbs_s1[6] ^ w_prbs_s1[5];
    w_prbs_s2   = {w_prbs_s1[5:0], w_prbs_fall};
  end

  // The generator only advances while its bits are actually being emitted
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      prbs_q <= 7'h7F;
    end else if (prbs_mode && (state_q == ST_IDLE)) begin
      prbs_q <= w_prbs_s2;
    end
  end

  assign w_fill = prbs_mode ? {LANES{w_prbs_fall, w_prbs_rise}} : {LANES{IDLE_PAIR}};
`else
  assign w_fill = {LANES{IDLE_PAIR}};
`endif

  // Control FSM with registered DDR outputs; the slot chosen in one cycle is
  // presented on the pins in the next, with the clock pair aligned to it.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      word_q      <= '0;
      ddr_q       <= {LANES{IDLE_PAIR}};
      clk_q       <= 2'b00;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;

      if (state_q != ST_IDLE) begin
        ddr_q <= word_q[slot_q];
        clk_q <= 2'b01;
      end else begin
        ddr_q <= w_fill;
        clk_q <= 2'b00;
      end

      if (w_load) begin
        word_q <= mem_q[rptr_q];
      end

      case (state_q)
        ST_IDLE: begin
          if (w_load) begin
            state_q <= ST_RUN;
            slot_q  <= '0;
          end
        end
        ST_RUN: begin
          if (slot_q == LAST_SLOT) begin
            slot_q <= '0;
            if (!enable) begin
              state_q <= ST_IDLE;
            end else if (count_q == '0) begin
              state_q     <= ST_IDLE;
              underflow_q <= 1'b1;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
            if (!enable) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (slot_q == LAST_SLOT) begin
            slot_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          slot_q  <= '0;
        end
      endcase
    end
  end

  assign ddr_data     = ddr_q;
  assign clk_ddr_data = clk_q;
  assign underflow    = underflow_q;
  assign active       = (state_q != ST_IDLE);
  assign level        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_aes50_txd_gearbox.sv
// ============================================================================
// Module      : tb_aes50_txd_gearbox
// Description : Directed self-checking bench for aes50_txd_gearbox
//               (LANES=3, RATIO=4, DEPTH=4, START_LEVEL=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes50_txd_gearbox;

  localparam int LANES       = 3;
  localparam int RATIO       = 4;
  localparam int DEPTH       = 4;
  localparam int START_LEVEL = 1;

  logic        refclk  = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
`ifdef AES50_TXD_PRBS_EN
  logic        prbs_mode = 1'b0;
`endif
  logic [5:0]  ddr_data;
  logic [1:0]  clk_ddr_data;
  logic        active;
  logic        underflow;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] words [8];
  logic [23:0] cur_word;
  int          idx;
  int          beats;
  logic        acc;
  logic        gap;
  logic        saw_full;
`ifdef AES50_TXD_PRBS_EN
  logic [6:0]  lfsr;
  logic        b0;
  logic        b1;
`endif

  aes50_txd_gearbox_if #(.LANES(LANES), .RATIO(RATIO)) bus ();

  aes50_txd_gearbox #(
    .LANES       (LANES),
    .RATIO       (RATIO),
    .DEPTH       (DEPTH),
    .START_LEVEL (START_LEVEL),
    .IDLE_PAIR   (2'b00)
  ) dut (
    .refclk       (refclk),
    .reset_n      (reset_n),
    .enable       (enable),
`ifdef AES50_TXD_PRBS_EN
    .prbs_mode    (prbs_mode),
`endif
    .in_if        (bus),
    .ddr_data     (ddr_data),
    .clk_ddr_data (clk_ddr_data),
    .active       (active),
    .underflow    (underflow),
    .level        (level)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset with valid asserted ----------------
    reset_n      = 1'b0;
    enable       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'hFFFFFF;
`ifdef AES50_TXD_PRBS_EN
    prbs_mode    = 1'b1;
`endif
    repeat (3) tick();
    chk("rst_ddr",      32'(ddr_data),     32'h0);
    chk("rst_clk",      32'(clk_ddr_data), 32'h0);
    chk("rst_level",    32'(level),        32'h0);
    chk("rst_ready",    32'(bus.in_ready), 32'h1);
    chk("rst_active",   32'(active),       32'h0);
    chk("rst_underflow",32'(underflow),    32'h0);
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    enable       = 1'b0;

`ifdef AES50_TXD_PRBS_EN
    // ---------------- PRBS idle fill from seed ----------------
    lfsr = 7'h7F;
    for (int i = 0; i < 7; i++) begin
      tick();
      b0   = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], b0};
      b1   = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], b1};
      chk("prbs_fill", 32'(ddr_data), 32'({3{b1, b0}}));
      chk("prbs_clk",  32'(clk_ddr_data), 32'h0);
    end
    prbs_mode = 1'b0;
    tick();
`endif

    tick();
    chk("idle_ddr",    32'(ddr_data), 32'h0);
    chk("idle_active", 32'(active),   32'h0);

    // ---------------- single word, latency and underflow ----------------
    bus.in_data  = 24'hABCDEF;
    bus.in_valid = 1'b1;
    enable       = 1'b1;
    tick();                                   // write edge
    bus.in_valid = 1'b0;
    chk("sw_level1", 32'(level), 32'h1);
    tick();                                   // shifter loads
    chk("sw_ddr_pre", 32'(ddr_data), 32'h0);
    chk("sw_active",  32'(active),   32'h1);
    chk("sw_level0",  32'(level),    32'h0);
    tick();
    chk("sw_slot0", 32'(ddr_data),     32'h2F);
    chk("sw_clk",   32'(clk_ddr_data), 32'h1);
    tick();
    chk("sw_slot1", 32'(ddr_data), 32'h37);
    tick();
    chk("sw_slot2", 32'(ddr_data), 32'h3C);
    tick();
    chk("sw_slot3", 32'(ddr_data),  32'h2A);
    chk("sw_uf",    32'(underflow), 32'h1);
    tick();
    chk("sw_idle_ddr", 32'(ddr_data),     32'h0);
    chk("sw_idle_clk", 32'(clk_ddr_data), 32'h0);
    chk("sw_uf_end",   32'(underflow),    32'h0);
    chk("sw_idle_act", 32'(active),       32'h0);

    // ---------------- back-to-back eight words ----------------
    for (int i = 0; i < 8; i++) begin
      words[i] = 24'h3C5A96 ^ (24'(i) * 24'h111111);
    end
    idx      = 0;
    beats    = 0;
    gap      = 1'b0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 80 && beats < 32; cyc++) begin
      bus.in_valid = (idx < 8);
      bus.in_data  = words[(idx < 8) ? idx : 7];
      acc          = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
      if (level == 3'd4) begin
        saw_full = 1'b1;
        chk("b2b_ready_full", 32'(bus.in_ready), 32'h0);
      end
      if (clk_ddr_data == 2'b01) begin
        cur_word = words[beats / 4];
        chk("b2b_data", 32'(ddr_data), 32'(cur_word[(beats % 4) * 6 +: 6]));
        if (beats < 31) chk("b2b_no_uf", 32'(underflow), 32'h0);
        beats++;
      end else if (beats > 0) begin
        gap = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_beats",    32'(beats),    32'd32);
    chk("b2b_no_gap",   32'(gap),      32'h0);
    chk("b2b_saw_full", 32'(saw_full), 32'h1);
    chk("b2b_writes",   32'(idx),      32'd8);
    tick();
    tick();
    chk("b2b_end_act", 32'(active), 32'h0);

    // ---------------- drain on enable drop ----------------
    enable       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h123456;
    tick();
    bus.in_data  = 24'h654321;
    tick();
    bus.in_data  = 24'hFEDCBA;
    tick();
    bus.in_valid = 1'b0;
    chk("dr_level3", 32'(level),  32'h3);
    chk("dr_idle",   32'(active), 32'h0);
    enable = 1'b1;
    tick();                                   // load first word
    chk("dr_level2", 32'(level), 32'h2);
    tick();
    chk("dr_slot0", 32'(ddr_data), 32'h16);
    enable = 1'b0;                            // seen while slot 1 is selected
    tick();
    chk("dr_slot1",  32'(ddr_data), 32'h11);
    chk("dr_active", 32'(active),   32'h1);
    tick();
    chk("dr_slot2", 32'(ddr_data), 32'h23);
    enable = 1'b1;                            // must be ignored while draining
    tick();
    chk("dr_slot3",    32'(ddr_data), 32'h04);
    chk("dr_hold_lvl", 32'(level),    32'h2);
    enable = 1'b0;
    tick();
    chk("dr_end_ddr",  32'(ddr_data),     32'h0);
    chk("dr_end_clk",  32'(clk_ddr_data), 32'h0);
    chk("dr_end_act",  32'(active),       32'h0);
    chk("dr_retained", 32'(level),        32'h2);

    // ---------------- asynchronous reset mid-word ----------------
    enable = 1'b1;
    tick();                                   // load second word
    tick();
    chk("ar_slot0", 32'(ddr_data), 32'h21);
    tick();
    chk("ar_slot1", 32'(ddr_data), 32'h0C);
    chk("ar_level", 32'(level),    32'h1);
    reset_n = 1'b0;                           // slot 2 is selected now
    #1;
    chk("ar_ddr",    32'(ddr_data),     32'h0);
    chk("ar_clk",    32'(clk_ddr_data), 32'h0);
    chk("ar_lvl",    32'(level),        32'h0);
    chk("ar_act",    32'(active),       32'h0);
    chk("ar_ready",  32'(bus.in_ready), 32'h1);
    tick();
    chk("ar_hold", 32'(ddr_data), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_post_ddr", 32'(ddr_data),     32'h0);
      chk("ar_post_clk", 32'(clk_ddr_data), 32'h0);
      chk("ar_post_lvl", 32'(level),        32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
